stack_spill_ctl: RTL and testbench

//  Spill/fill controller for the on-chip operand stack read at decode and written at writeback.

---
 rtl/stack_spill_pkg.sv | 20 ++
 rtl/stack_spill_ctl.sv | 165 ++++++++++++++++
 tb/tb_stack_spill_ctl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/stack_spill_pkg.sv
// Shared types and sizing helpers for the operand-stack spill/fill controller.
package stack_spill_pkg;

    localparam int ST_WIDTH = 35;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } state_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int mem_cnt_width(input int mem_depth);
        return $clog2(mem_depth + 1);
    endfunction

endpackage

// File: rtl/stack_spill_ctl.sv
// Spill/fill controller: tracks on-chip stack occupancy, moves the bottom entry to and from
// backing memory around the watermarks, and stalls decode when room or operands are at risk.
//
// state | meaning
// IDLE  | no backing-store request outstanding
// SPILL | write of the bottom entry outstanding, waiting for mem__ack
// FILL  | read of the top backing-store entry outstanding, waiting for mem__ack
module stack_spill_ctl
    import stack_spill_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int          HI_WM      = 12,
    parameter int          LO_WM      = 4,
    parameter int          MEM_DEPTH  = 1024,
    parameter logic [31:0] SPILL_BASE = 32'h0001_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                st__push_5a,
    input  logic                st__pop_5a,
    input  logic [1:0]          st__to_pop_5a,
    input  logic [ST_WIDTH-1:0] st__bot_data,
    output logic                st__bot_drop,
    output logic                st__bot_fill,
    output logic [ST_WIDTH-1:0] st__fill_data,
    output logic                mem__req,
    output logic                mem__we,
    output logic [31:0]         mem__addr,
    output logic [ST_WIDTH-1:0] mem__wdata,
    input  logic [ST_WIDTH-1:0] mem__rdata,
    input  logic                mem__ack,
    output logic                sp__stall_2a,
    output logic                sp__overflow,
    output logic                sp__underflow
);

    localparam int OW = occ_width(DEPTH);
    localparam int MW = mem_cnt_width(MEM_DEPTH);

    localparam logic [OW-1:0] C_DEPTH   = OW'(DEPTH);
    localparam logic [OW-1:0] C_DEPTH_1 = OW'(DEPTH - 1);
    localparam logic [OW-1:0] C_HI_WM   = OW'(HI_WM);
    localparam logic [OW-1:0] C_LO_WM   = OW'(LO_WM);
    localparam logic [OW-1:0] C_TWO     = OW'(2);
    localparam logic [MW-1:0] C_MEM_MAX = MW'(MEM_DEPTH);

    state_t                r_state;
    logic [OW-1:0]         r_occ;
    logic [MW-1:0]         r_mem_cnt;
    logic                  r_req;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [ST_WIDTH-1:0]   r_wdata;
    logic                  r_drop;
    logic                  r_fill;
    logic [ST_WIDTH-1:0]   r_fill_data;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_ack_spill;
    logic                  w_ack_fill;
    logic                  w_push_ok;
    logic                  w_overflow;
    logic [1:0]            w_pop_cnt;
    logic [OW:0]           w_up;
    logic [OW:0]           w_dn;
    logic [OW:0]           w_occ_diff;
    logic                  w_underflow;
    logic                  w_spill_go;
    logic                  w_fill_go;

    // Acks only count while a request is outstanding; a stray ack in IDLE does nothing.
    assign w_ack_spill = (r_state == SPILL) && mem__ack;
    assign w_ack_fill  = (r_state == FILL) && mem__ack;

    assign w_overflow  = st__push_5a && (r_occ == C_DEPTH);
    assign w_push_ok   = st__push_5a && !w_overflow;
    assign w_pop_cnt   = st__pop_5a ? st__to_pop_5a : 2'd0;

    // All occupancy terms of one cycle are combined before saturating at zero.
    assign w_up        = {1'b0, r_occ} + (OW+1)'(w_push_ok) + (OW+1)'(w_ack_fill);
    assign w_dn        = (OW+1)'(w_pop_cnt) + (OW+1)'(w_ack_spill);
    assign w_underflow = (w_dn > w_up);
    assign w_occ_diff  = w_up - w_dn;

    assign w_spill_go  = (r_occ > C_HI_WM) && (r_mem_cnt < C_MEM_MAX);
    assign w_fill_go   = (r_occ < C_LO_WM) && (r_mem_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_occ       <= '0;
            r_mem_cnt   <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_drop      <= 1'b0;
            r_fill      <= 1'b0;
            r_fill_data <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            r_fill <= 1'b0;
            r_occ  <= w_underflow ? '0 : w_occ_diff[OW-1:0];
            if (w_overflow)  r_ovf <= 1'b1;
            if (w_underflow) r_unf <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_spill_go) begin
                        r_state <= SPILL;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= SPILL_BASE + 32'(r_mem_cnt);
                        r_wdata <= st__bot_data;
                    end else if (w_fill_go) begin
                        r_state <= FILL;
                        r_req   <= 1'b1;
                        r_we    <= 1'b0;
                        r_addr  <= SPILL_BASE + 32'(r_mem_cnt) - 32'd1;
                    end
                end
                SPILL: begin
                    if (mem__ack) begin
                        r_state   <= IDLE;
                        r_req     <= 1'b0;
                        r_we      <= 1'b0;
                        r_drop    <= 1'b1;
                        r_mem_cnt <= r_mem_cnt + MW'(1);
                    end
                end
                FILL: begin
                    if (mem__ack) begin
                        r_state     <= IDLE;
                        r_req       <= 1'b0;
                        r_fill      <= 1'b1;
                        r_fill_data <= mem__rdata;
                        r_mem_cnt   <= r_mem_cnt - MW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign sp__stall_2a  = (r_occ >= C_DEPTH_1)
                         || ((r_occ < C_TWO) && (r_mem_cnt != '0))
                         || ((r_state == FILL) && (r_occ < C_TWO));

    assign st__bot_drop  = r_drop;
    assign st__bot_fill  = r_fill;
    assign st__fill_data = r_fill_data;
    assign mem__req      = r_req;
    assign mem__we       = r_we;
    assign mem__addr     = r_addr;
    assign mem__wdata    = r_wdata;
    assign sp__overflow  = r_ovf;
    assign sp__underflow = r_unf;

endmodule

// File: tb/tb_stack_spill_ctl.sv
// Directed bench for stack_spill_ctl: occupancy tracking, spill/fill handshakes, stall and sticky flags.
module tb_stack_spill_ctl;
    import stack_spill_pkg::*;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic                clk = 1'b0;
    logic                rst;
    logic                st__push_5a, st__pop_5a;
    logic [1:0]          st__to_pop_5a;
    logic [ST_WIDTH-1:0] st__bot_data;
    logic                st__bot_drop, st__bot_fill;
    logic [ST_WIDTH-1:0] st__fill_data;
    logic                mem__req, mem__we;
    logic [31:0]         mem__addr;
    logic [ST_WIDTH-1:0] mem__wdata, mem__rdata;
    logic                mem__ack;
    logic                sp__stall_2a, sp__overflow, sp__underflow;

    int checks = 0;
    int errors = 0;

    stack_spill_ctl dut (
        .clk(clk), .rst(rst),
        .st__push_5a(st__push_5a), .st__pop_5a(st__pop_5a), .st__to_pop_5a(st__to_pop_5a),
        .st__bot_data(st__bot_data), .st__bot_drop(st__bot_drop), .st__bot_fill(st__bot_fill),
        .st__fill_data(st__fill_data), .mem__req(mem__req), .mem__we(mem__we),
        .mem__addr(mem__addr), .mem__wdata(mem__wdata), .mem__rdata(mem__rdata),
        .mem__ack(mem__ack), .sp__stall_2a(sp__stall_2a), .sp__overflow(sp__overflow),
        .sp__underflow(sp__underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        st__push_5a = 0; st__pop_5a = 0; st__to_pop_5a = 0; mem__ack = 0; mem__rdata = '0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst = 1; step(2); rst = 0;
    endtask

    task automatic test_reset();
        st__bot_data = '0;
        pulse_reset();
        checks++; if ({mem__req, mem__we, st__bot_drop, st__bot_fill, sp__stall_2a, sp__overflow, sp__underflow} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {mem__req, mem__we, st__bot_drop, st__bot_fill, sp__stall_2a, sp__overflow, sp__underflow}); end
        checks++; if ({mem__addr, mem__wdata, st__fill_data} !== '0) begin errors++; $display("FAIL reset_buses: addr %h wdata %h fill %h expected 0", mem__addr, mem__wdata, st__fill_data); end
        checks++; if (dut.r_occ !== 5'd0 || dut.r_mem_cnt !== 11'd0 || dut.r_state !== IDLE) begin errors++; $display("FAIL reset_state: occ %0d mem %0d state %0d expected 0 0 0", dut.r_occ, dut.r_mem_cnt, dut.r_state); end
    endtask

    task automatic test_no_spill();
        int reqs = 0;
        st__push_5a = 1;
        for (int i = 0; i < 10; i++) begin step(); if (mem__req) reqs++; end
        st__push_5a = 0; step(); if (mem__req) reqs++;
        checks++; if (reqs !== 0) begin errors++; $display("FAIL ten_push_req: got %0d req cycles expected 0", reqs); end
        checks++; if (dut.r_occ !== 5'd10) begin errors++; $display("FAIL ten_push_occ: got %0d expected 10", dut.r_occ); end
        checks++; if (sp__stall_2a !== 1'b0) begin errors++; $display("FAIL ten_push_stall: got %b expected 0", sp__stall_2a); end
    endtask

    task automatic test_spill();
        int drops = 0;
        st__bot_data = 35'h4_1234_5678;
        st__push_5a = 1; step(3); st__push_5a = 0;
        checks++; if (dut.r_occ !== 5'd13 || mem__req !== 1'b0) begin errors++; $display("FAIL spill_pre: occ %0d req %b expected 13 0", dut.r_occ, mem__req); end
        step();
        checks++; if ({mem__req, mem__we} !== 2'b11 || mem__addr !== BASE || mem__wdata !== 35'h4_1234_5678) begin errors++; $display("FAIL spill_req: req/we %b addr %h wdata %h expected 11 %h 412345678", {mem__req, mem__we}, mem__addr, mem__wdata, BASE); end
        st__bot_data = 35'h0_0BAD_BEEF;
        step(2);
        checks++; if (mem__req !== 1'b1 || mem__wdata !== 35'h4_1234_5678 || st__bot_drop !== 1'b0) begin errors++; $display("FAIL spill_hold: req %b wdata %h drop %b expected 1 412345678 0", mem__req, mem__wdata, st__bot_drop); end
        mem__ack = 1; step(); mem__ack = 0;
        if (st__bot_drop) drops++;
        checks++; if (dut.r_occ !== 5'd12 || dut.r_mem_cnt !== 11'd1 || mem__req !== 1'b0 || st__bot_drop !== 1'b1) begin errors++; $display("FAIL spill_ack: occ %0d mem %0d req %b drop %b expected 12 1 0 1", dut.r_occ, dut.r_mem_cnt, mem__req, st__bot_drop); end
        for (int i = 0; i < 3; i++) begin step(); if (st__bot_drop) drops++; end
        checks++; if (drops !== 1 || mem__req !== 1'b0) begin errors++; $display("FAIL spill_drop_once: drops %0d req %b expected 1 0", drops, mem__req); end
    endtask

    task automatic test_fill();
        st__pop_5a = 1; st__to_pop_5a = 2; step(4);
        st__to_pop_5a = 1; step();
        clear_inputs();
        checks++; if (dut.r_occ !== 5'd3 || mem__req !== 1'b0) begin errors++; $display("FAIL fill_pre: occ %0d req %b expected 3 0", dut.r_occ, mem__req); end
        step();
        checks++; if ({mem__req, mem__we} !== 2'b10 || mem__addr !== BASE || dut.r_state !== FILL) begin errors++; $display("FAIL fill_req: req/we %b addr %h state %0d expected 10 %h 2", {mem__req, mem__we}, mem__addr, dut.r_state, BASE); end
        step();
        mem__rdata = 35'h5A5A; mem__ack = 1; step(); clear_inputs();
        checks++; if (st__bot_fill !== 1'b1 || st__fill_data !== 35'h5A5A || dut.r_occ !== 5'd4 || dut.r_mem_cnt !== 11'd0 || mem__req !== 1'b0) begin errors++; $display("FAIL fill_ack: fill %b data %h occ %0d mem %0d req %b expected 1 5a5a 4 0 0", st__bot_fill, st__fill_data, dut.r_occ, dut.r_mem_cnt, mem__req); end
        step();
        checks++; if (st__bot_fill !== 1'b0 || mem__req !== 1'b0) begin errors++; $display("FAIL fill_pulse: fill %b req %b expected 0 0", st__bot_fill, mem__req); end
    endtask

    task automatic test_ack_coincident();
        st__push_5a = 1; step(9); st__push_5a = 0; step();
        checks++; if (mem__req !== 1'b1 || dut.r_occ !== 5'd13) begin errors++; $display("FAIL coinc_pre: req %b occ %0d expected 1 13", mem__req, dut.r_occ); end
        st__push_5a = 1; st__pop_5a = 1; st__to_pop_5a = 2; mem__ack = 1; step(); clear_inputs();
        checks++; if (dut.r_occ !== 5'd11 || dut.r_mem_cnt !== 11'd1 || st__bot_drop !== 1'b1) begin errors++; $display("FAIL coinc_ack: occ %0d mem %0d drop %b expected 11 1 1", dut.r_occ, dut.r_mem_cnt, st__bot_drop); end
    endtask

    task automatic test_underflow();
        pulse_reset();
        st__push_5a = 1; step(); st__push_5a = 0;
        checks++; if (dut.r_occ !== 5'd1 || sp__underflow !== 1'b0) begin errors++; $display("FAIL unf_pre: occ %0d unf %b expected 1 0", dut.r_occ, sp__underflow); end
        st__pop_5a = 1; st__to_pop_5a = 2; step(); clear_inputs();
        checks++; if (dut.r_occ !== 5'd0 || sp__underflow !== 1'b1) begin errors++; $display("FAIL unf_set: occ %0d unf %b expected 0 1", dut.r_occ, sp__underflow); end
        step(3); st__push_5a = 1; step(); st__push_5a = 0; step();
        checks++; if (sp__underflow !== 1'b1 || dut.r_occ !== 5'd1) begin errors++; $display("FAIL unf_sticky: unf %b occ %0d expected 1 1", sp__underflow, dut.r_occ); end
        pulse_reset();
        checks++; if (sp__underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", sp__underflow); end
    endtask

    task automatic test_overflow();
        pulse_reset();
        st__push_5a = 1; step(15);
        checks++; if (sp__stall_2a !== 1'b1 || mem__req !== 1'b1 || dut.r_occ !== 5'd15) begin errors++; $display("FAIL ovf_stall: stall %b req %b occ %0d expected 1 1 15", sp__stall_2a, mem__req, dut.r_occ); end
        step();
        checks++; if (dut.r_occ !== 5'd16 || sp__overflow !== 1'b0) begin errors++; $display("FAIL ovf_full: occ %0d ovf %b expected 16 0", dut.r_occ, sp__overflow); end
        step(); st__push_5a = 0;
        checks++; if (dut.r_occ !== 5'd16 || sp__overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: occ %0d ovf %b expected 16 1", dut.r_occ, sp__overflow); end
        mem__ack = 1; step(); mem__ack = 0;
        checks++; if (dut.r_occ !== 5'd15 || dut.r_mem_cnt !== 11'd1 || sp__overflow !== 1'b1) begin errors++; $display("FAIL ovf_drain: occ %0d mem %0d ovf %b expected 15 1 1", dut.r_occ, dut.r_mem_cnt, sp__overflow); end
    endtask

    task automatic test_rst_during_fill();
        pulse_reset();
        st__push_5a = 1; step(13); st__push_5a = 0; step();
        mem__ack = 1; step(); mem__ack = 0;
        st__pop_5a = 1; st__to_pop_5a = 2; step(5); clear_inputs();
        step();
        checks++; if ({mem__req, mem__we} !== 2'b10 || dut.r_state !== FILL || dut.r_occ !== 5'd2) begin errors++; $display("FAIL rstfill_req: req/we %b state %0d occ %0d expected 10 2 2", {mem__req, mem__we}, dut.r_state, dut.r_occ); end
        st__pop_5a = 1; st__to_pop_5a = 1; step(); clear_inputs();
        checks++; if (sp__stall_2a !== 1'b1 || dut.r_occ !== 5'd1) begin errors++; $display("FAIL rstfill_stall: stall %b occ %0d expected 1 1", sp__stall_2a, dut.r_occ); end
        rst = 1; step(); rst = 0;
        checks++; if (mem__req !== 1'b0 || dut.r_occ !== 5'd0 || dut.r_state !== IDLE || dut.r_mem_cnt !== 11'd0) begin errors++; $display("FAIL rstfill_rst: req %b occ %0d state %0d mem %0d expected 0 0 0 0", mem__req, dut.r_occ, dut.r_state, dut.r_mem_cnt); end
        mem__rdata = 35'h7; mem__ack = 1; step(); clear_inputs();
        checks++; if (st__bot_fill !== 1'b0 || dut.r_occ !== 5'd0 || dut.r_mem_cnt !== 11'd0 || mem__req !== 1'b0) begin errors++; $display("FAIL stray_ack: fill %b occ %0d mem %0d req %b expected 0 0 0 0", st__bot_fill, dut.r_occ, dut.r_mem_cnt, mem__req); end
        step();
        checks++; if (dut.r_state !== IDLE || mem__req !== 1'b0 || st__bot_fill !== 1'b0) begin errors++; $display("FAIL stray_after: state %0d req %b fill %b expected 0 0 0", dut.r_state, mem__req, st__bot_fill); end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        st__bot_data = '0;
        test_reset();
        test_no_spill();
        test_spill();
        test_fill();
        test_ack_coincident();
        test_underflow();
        test_overflow();
        test_rst_during_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
